// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request feeding a DEPTH-entry prefetch queue.
// Defining FETCH_PERF_EN adds saturating perf_fetches / perf_flushes counter outputs.
module fetch_unit #(
    parameter int PC_WIDTH    = 22,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hlt,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_re,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]            perf_fetches,
    output logic [15:0]            perf_flushes
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]       DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]       ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]       PONE_C  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [PC_WIDTH-1:0] PC_ONE_C = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_ISSUE   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2,
        ST_HALTED  = 2'd3
    } state_t;

    state_t                 state_r, state_next_s;
    logic                   halt_pend_r, halt_eff_s;
    logic                   issue_s, push_s, pop_s, flush_s;
    logic [PC_WIDTH-1:0]    fetch_pc_r;
    logic [CW-1:0]          count_r;
    logic [AW-1:0]          wr_ptr_r, rd_ptr_r;
    logic [PC_WIDTH-1:0]    mem_pc_r    [DEPTH];
    logic [INSTR_WIDTH-1:0] mem_instr_r [DEPTH];

    // A hlt pulse takes effect in its own cycle and stays pending afterwards.
    assign halt_eff_s = halt_pend_r | hlt;
    assign flush_s    = redirect & (state_r != ST_HALTED);
    assign pop_s      = out_valid & out_ready;

    assign imem_re   = issue_s & ~rst;
    assign imem_addr = rst ? {PC_WIDTH{1'b0}} : fetch_pc_r;
    assign out_valid = (count_r != {CW{1'b0}});
    assign out_instr = out_valid ? mem_instr_r[rd_ptr_r] : {INSTR_WIDTH{1'b0}};
    assign out_pc    = out_valid ? mem_pc_r[rd_ptr_r] : {PC_WIDTH{1'b0}};
    assign pc        = fetch_pc_r;
    assign halted    = (state_r == ST_HALTED);

    // Next-state, request issue and push decision.
    always_comb begin
        state_next_s = state_r;
        issue_s      = 1'b0;
        push_s       = 1'b0;
        case (state_r)
            ST_ISSUE: begin
                if (halt_eff_s) begin
                    state_next_s = ST_HALTED;
                end else if (!redirect && (count_r < DEPTH_C)) begin
                    issue_s      = 1'b1;
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (imem_valid) begin
                    push_s       = ~redirect;
                    state_next_s = halt_eff_s ? ST_HALTED : ST_ISSUE;
                end else if (redirect) begin
                    state_next_s = ST_DISCARD;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DISCARD: begin
                if (imem_valid) begin
                    state_next_s = halt_eff_s ? ST_HALTED : ST_ISSUE;
                end else begin
                    state_next_s = ST_DISCARD;
                end
            end
            ST_HALTED: begin
                state_next_s = ST_HALTED;
            end
            default: begin
                state_next_s = ST_ISSUE;
            end
        endcase
    end

    // FSM state, halt-pending flag and fetch address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_ISSUE;
            halt_pend_r <= 1'b0;
            fetch_pc_r  <= RESET_PC;
        end else begin
            state_r     <= state_next_s;
            halt_pend_r <= halt_pend_r | hlt;
            if (flush_s) begin
                fetch_pc_r <= redirect_pc;
            end else if (push_s) begin
                fetch_pc_r <= fetch_pc_r + PC_ONE_C;
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r  <= {CW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else if (flush_s) begin
            count_r  <= {CW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PONE_C;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PONE_C;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; contents are only observed through out_valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_pc_r[wr_ptr_r]    <= fetch_pc_r;
            mem_instr_r[wr_ptr_r] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetches_r, perf_flushes_r;

    // Saturating event counters; neither event can occur once HALTED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetches_r <= 16'd0;
            perf_flushes_r <= 16'd0;
        end else begin
            if (push_s && (perf_fetches_r != 16'hFFFF)) perf_fetches_r <= perf_fetches_r + 16'd1;
            if (flush_s && (perf_flushes_r != 16'hFFFF)) perf_flushes_r <= perf_flushes_r + 16'd1;
        end
    end

    assign perf_fetches = perf_fetches_r;
    assign perf_flushes = perf_flushes_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected {pc, instr} entries and a
// monitor process pops and compares each instruction accepted by decode.
module tb_fetch_unit;
    localparam int PW = 22;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst, hlt, redirect, out_ready;
    logic          imem_valid;
    logic [PW-1:0] redirect_pc, imem_addr, out_pc, pc;
    logic [IW-1:0] imem_rdata, out_instr;
    logic          imem_re, out_valid, halted;
`ifdef FETCH_PERF_EN
    logic [15:0]   perf_fetches, perf_flushes;
`endif

    typedef struct { logic [PW-1:0] pc; logic [IW-1:0] instr; } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int mem_lat = 1;

    fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .DEPTH(4), .RESET_PC(22'h000000)) dut (
        .clk(clk), .rst(rst), .hlt(hlt), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_re(imem_re), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .pc(pc), .halted(halted)
`ifdef FETCH_PERF_EN
        , .perf_fetches(perf_fetches), .perf_flushes(perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: accepts a request seen at negedge, answers mem_lat cycles later.
    initial begin
        logic          busy;
        int            cnt;
        logic [PW-1:0] a;
        busy = 1'b0; cnt = 0; a = '0;
        imem_valid = 1'b0; imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) busy = 1'b0;
            else if (!busy && imem_re) begin busy = 1'b1; cnt = mem_lat; a = imem_addr; end
            @(posedge clk); #1;
            imem_valid = 1'b0;
            if (busy && !rst) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = {16'hAAAA, a[15:0]};
                    busy = 1'b0;
                end
            end
        end
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void push_exp(input logic [PW-1:0] a, input logic [IW-1:0] d);
        exp_t e;
        e.pc = a; e.instr = d;
        exp_q.push_back(e);
    endfunction

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL sb_extra: got out_pc %0h instr %0h expected no output", out_pc, out_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", out_pc, e.pc);
                    chk("sb_instr", out_instr, e.instr);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_req(input logic [PW-1:0] exp_addr, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (imem_re) seen = 1'b1;
        end
        chk({name, "_seen"}, seen, 1);
        if (seen) chk(name, imem_addr, exp_addr);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1; hlt = 1'b0; redirect = 1'b0;
        @(negedge clk);
        chk("rst_imem_re", imem_re, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_pc", pc, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int prev, nreq;
        logic [PW-1:0] a;
        rst = 1'b1; hlt = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        fork monitor_loop(); join_none

        // Streaming with latency 1: one request every 2 cycles, then a halt in WAIT.
        mem_lat = 1;
        do_reset();
        for (int k = 0; k < 6; k++) push_exp(PW'(k), {16'hAAAA, 16'(k)});
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            wait_req(PW'(k), "t2_addr");
            if (k > 0) chk("t2_gap", 64'(cyc - prev), 2);
            if (k == 1) begin
                chk("t2_first_valid", out_valid, 1);
                chk("t2_first_pc", out_pc, 0);
            end
            prev = cyc;
        end
        tick(); hlt = 1'b1;
        tick(); hlt = 1'b0;
        @(negedge clk);
        chk("t2_halted", halted, 1);
        chk("t2_no_req", imem_re, 0);
        chk("t2_pc", pc, 6);
        tick(); redirect = 1'b1; redirect_pc = 22'h000100;
        @(negedge clk);
        chk("t2_halt_redirect_re", imem_re, 0);
        tick(); redirect = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("t2_halt_redirect_pc", pc, 6);
        chk("t2_drained", out_valid, 0);
        chk("t2_still_halted", halted, 1);
        chk("t2_sb_empty", exp_q.size(), 0);

        // Decode stalled: exactly DEPTH pushes, then in-order drain after halting.
        out_ready = 1'b0;
        do_reset();
        push_exp(22'h000000, 32'hAAAA0000);
        push_exp(22'h000001, 32'hAAAA0001);
        push_exp(22'h000002, 32'hAAAA0002);
        push_exp(22'h000003, 32'hAAAA0003);
        nreq = 0;
        repeat (20) begin
            @(negedge clk);
            if (imem_re) nreq++;
        end
        chk("t3_req_count", nreq, 4);
        chk("t3_no_req", imem_re, 0);
        chk("t3_full_valid", out_valid, 1);
        chk("t3_pc", pc, 4);
        tick(); hlt = 1'b1;
        tick(); hlt = 1'b0; out_ready = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        chk("t3_halted", halted, 1);
        chk("t3_drained", out_valid, 0);
        chk("t3_sb_empty", exp_q.size(), 0);

        // Redirect in WAIT with latency 2: stale response dropped, then wrap past 0x3FFFFF.
        mem_lat = 2; out_ready = 1'b1;
        do_reset();
        wait_req(22'h000000, "t4_addr0");
        tick(); redirect = 1'b1; redirect_pc = 22'h3FFFF0;
        tick(); redirect = 1'b0;
        @(negedge clk);
        chk("t4_flush_valid", out_valid, 0);
        chk("t4_redirect_pc", pc, 22'h3FFFF0);
        for (int k = 0; k < 17; k++) begin
            a = 22'h3FFFF0 + PW'(k);
            push_exp(a, {16'hAAAA, a[15:0]});
        end
        for (int k = 0; k < 17; k++) begin
            a = 22'h3FFFF0 + PW'(k);
            wait_req(a, (k == 16) ? "t4_wrap_addr" : "t4_addr");
            if (k == 0) begin
                chk("t4_no_valid_at_req", out_valid, 0);
                @(negedge clk);
                chk("t4_no_valid_waiting", out_valid, 0);
            end
        end
        tick(); hlt = 1'b1;
        tick(); hlt = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("t4_halted", halted, 1);
        chk("t4_no_req", imem_re, 0);
        chk("t4_sb_empty", exp_q.size(), 0);

        // Redirect flushes a non-empty queue; redirect in ISSUE suppresses the request.
        mem_lat = 1; out_ready = 1'b0;
        do_reset();
        wait_req(22'h000000, "t5_addr");
        wait_req(22'h000001, "t5_addr");
        wait_req(22'h000002, "t5_addr");
        tick(); redirect = 1'b1; redirect_pc = 22'h000040;
        tick(); redirect_pc = 22'h000080;
        @(negedge clk);
        chk("t5_issue_redirect_re", imem_re, 0);
        chk("t5_flush_valid", out_valid, 0);
        chk("t5_pc", pc, 22'h000040);
        tick(); redirect = 1'b0; out_ready = 1'b1;
        push_exp(22'h000080, 32'hAAAA0080);
        push_exp(22'h000081, 32'hAAAA0081);
        wait_req(22'h000080, "t5_addr_redir");
        wait_req(22'h000081, "t5_addr_redir");
        tick(); hlt = 1'b1;
        tick(); hlt = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("t5_halted", halted, 1);
        chk("t5_sb_empty", exp_q.size(), 0);
`ifdef FETCH_PERF_EN
        chk("t5_perf_fetches", perf_fetches, 4);
        chk("t5_perf_flushes", perf_flushes, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
